// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream generator.
// Optional feature macro: FIB_SEED_EN (user-supplied seeds instead of 0/1).
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

  // Seeds used when FIB_SEED_EN is not defined
  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fib_stream_gen_if.sv
// Command + term-stream bundle for fib_stream_gen.
// slave = generator side, master = requester/consumer side.
// Optional feature macro: FIB_SEED_EN adds seed0/seed1.
interface fib_stream_gen_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  logic          start;
  logic          start_ready;
  logic [CW-1:0] n;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_idx;
  logic          ovf;
  logic          done;
`ifdef FIB_SEED_EN
  logic [W-1:0]  seed0;
  logic [W-1:0]  seed1;

  modport slave (
    input  start, n, abort, out_ready, seed0, seed1,
    output start_ready, out_valid, out_data, out_idx, ovf, done
  );
  modport master (
    output start, n, abort, out_ready, seed0, seed1,
    input  start_ready, out_valid, out_data, out_idx, ovf, done
  );
`else
  modport slave (
    input  start, n, abort, out_ready,
    output start_ready, out_valid, out_data, out_idx, ovf, done
  );
  modport master (
    output start, n, abort, out_ready,
    input  start_ready, out_valid, out_data, out_idx, ovf, done
  );
`endif
endinterface

// File: rtl/fib_add_sat.sv
// W-bit adder with carry out; SAT=1 clamps the sum to all-ones on carry.
module fib_add_sat #(
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[W];

  // Saturating or wrapping result selected at elaboration
  generate
    if (SAT != 0) begin : g_sat
      assign sum = carry ? {W{1'b1}} : full[W-1:0];
    end else begin : g_wrap
      assign sum = full[W-1:0];
    end
  endgenerate

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci term generator: accepts a count n, streams F(0)..F(n-1) with
// valid/ready, flags overflow, pulses done after the last term.
// Optional feature macro: FIB_SEED_EN (F(0)/F(1) taken from seed0/seed1).
module fib_stream_gen
  import fib_pkg::*;
#(
  parameter int W   = 8,
  parameter int CW  = 8,
  parameter int SAT = 0
) (
  input logic             clk,
  input logic             rst_n,
  fib_stream_gen_if.slave bus
);

  fib_state_e    state_q, state_d;
  logic [W-1:0]  a_q, a_d;       // term currently shown, F(k)
  logic [W-1:0]  b_q, b_d;       // next term, F(k+1)
  logic          bovf_q, bovf_d; // true value of b has exceeded W bits
  logic [CW-1:0] rem_q, rem_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  f0, f1;
  logic [W-1:0]  sum;
  logic          carry;

`ifdef FIB_SEED_EN
  assign f0 = bus.seed0;
  assign f1 = bus.seed1;
`else
  assign f0 = W'(FIB_SEED0);
  assign f1 = W'(FIB_SEED1);
`endif

  fib_add_sat #(.W(W), .SAT(SAT)) u_add (
    .a    (a_q),
    .b    (b_q),
    .sum  (sum),
    .carry(carry)
  );

  // Next-state: command accept, term advance on handshake, abort, done
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    bovf_d  = bovf_q;
    rem_d   = rem_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = f0;
          b_d     = f1;
          bovf_d  = 1'b0;
          rem_d   = bus.n;
          data_d  = f0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = (bus.n != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          rem_d = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            // last term consumed; outputs keep showing it
            state_d = DONE;
          end else begin
            data_d = b_q;
            a_d    = b_q;
            b_d    = sum;
            // ovf follows the shown term, so it lags the carry by one step
            ovf_d  = ovf_q | bovf_q;
            bovf_d = bovf_q | carry;
            idx_d  = idx_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= W'(1);
      bovf_q  <= 1'b0;
      rem_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bovf_q  <= bovf_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.out_valid   = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.out_data    = data_q;
  assign bus.out_idx     = idx_q;
  assign bus.ovf         = ovf_q;

endmodule
